// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency memory between the
// instruction-fetch port (IF) and the data port (MEM). One access is in
// flight at a time. MEM normally wins; a starvation counter bounds how long
// a waiting fetch can be held off.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    // data port
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    // memory side
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int SW    = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;      // cycles left until completion
    logic           own_mem_q, own_mem_d; // 1 = access belongs to MEM
    logic           we_q, we_d;           // in-flight access is a store
    logic           killed_q, killed_d;   // in-flight fetch was cancelled
    logic [SW-1:0]  starve_q, starve_d;   // MEM grants while IF waited

    logic grant_mem, grant_if;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            own_mem_q <= 1'b0;
            we_q      <= 1'b0;
            killed_q  <= 1'b0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            own_mem_q <= own_mem_d;
            we_q      <= we_d;
            killed_q  <= killed_d;
            starve_q  <= starve_d;
        end
    end

    // Grant, access sequencing, completion and starvation tracking
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        own_mem_d = own_mem_q;
        we_d      = we_q;
        killed_d  = killed_q;
        starve_d  = starve_q;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if_ack    = 1'b0;
        if_rdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        unique case (state_q)
            IDLE: begin
                // MEM holds the older instruction, so it wins unless IF has
                // already been passed over STARVE_MAX times in a row.
                grant_mem = mem_req && !(if_req && starve_q == SW'(STARVE_MAX));
                grant_if  = if_req && !grant_mem;
                if (grant_mem) begin
                    ram_en    = 1'b1;
                    ram_we    = mem_we;
                    ram_addr  = mem_addr;
                    ram_wdata = mem_we ? mem_wdata : '0;
                    state_d   = BUSY;
                    cnt_d     = mem_we ? CNT_W'(1) : CNT_W'(MEM_LAT);
                    own_mem_d = 1'b1;
                    we_d      = mem_we;
                    killed_d  = 1'b0;
                end else if (grant_if) begin
                    ram_en    = 1'b1;
                    ram_addr  = if_addr;
                    state_d   = BUSY;
                    cnt_d     = CNT_W'(MEM_LAT);
                    own_mem_d = 1'b0;
                    we_d      = 1'b0;
                    killed_d  = 1'b0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                // A redirect cannot stop the memory, so the fetch runs to
                // completion and only its acknowledge is dropped.
                if (!own_mem_q && if_kill)
                    killed_d = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = IDLE;
                    killed_d = 1'b0;
                    if (own_mem_q) begin
                        mem_ack   = 1'b1;
                        mem_rdata = we_q ? '0 : ram_rdata;
                    end else if (!(killed_q || if_kill)) begin
                        if_ack   = 1'b1;
                        if_rdata = ram_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!if_req || grant_if)
            starve_d = '0;
        else if (grant_mem && starve_q < SW'(STARVE_MAX))
            starve_d = starve_q + SW'(1);

        // Hold every output quiet while reset is asserted
        if (rst) begin
            ram_en    = 1'b0;
            ram_we    = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
            if_ack    = 1'b0;
            if_rdata  = '0;
            mem_ack   = 1'b0;
            mem_rdata = '0;
        end
    end

    // Pipeline stall requests
    always_comb begin
        if_stall  = ~rst & if_req & ~if_ack;
        mem_stall = ~rst & mem_req & ~mem_ack;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4).
// The memory model returns addr + 0x1000_0000 two cycles after ram_en.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, if_ack, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        mem_req, mem_we, mem_ack, mem_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Two-cycle latency memory model
    logic        p1v = 1'b0, p2v = 1'b0;
    logic [31:0] p1a = '0, p2a = '0;
    always @(posedge clk) begin
        p1v <= ram_en;
        p1a <= ram_addr;
        p2v <= p1v;
        p2a <= p1a;
    end
    assign ram_rdata = p2v ? p2a + 32'h1000_0000 : 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs are driven right after the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before checking
    task automatic settle;
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; if_kill = 0;
        mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
        tick; tick;
        if_req = 1'b1; if_addr = 32'h600; settle;
        chk("rst_ram_en", ram_en, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_if_stall", if_stall, 0);
        if_req = 1'b0;
        tick;

        // 1: single fetch
        rst = 1'b0; if_req = 1; if_addr = 32'h100; settle;
        chk("t1_ram_en", ram_en, 1);
        chk("t1_ram_addr", ram_addr, 32'h100);
        chk("t1_ram_we", ram_we, 0);
        chk("t1_stall_c1", if_stall, 1);
        tick; settle;
        chk("t1_busy_en", ram_en, 0);
        chk("t1_ack_c2", if_ack, 0);
        chk("t1_stall_c2", if_stall, 1);
        tick; settle;
        chk("t1_ack_c3", if_ack, 1);
        chk("t1_rdata", if_rdata, 32'h1000_0100);
        chk("t1_stall_c3", if_stall, 0);
        chk("t1_memack", mem_ack, 0);
        if_req = 0;
        tick; settle;
        chk("t1_ack_c4", if_ack, 0);
        chk("t1_rdata0", if_rdata, 0);

        // 2: simultaneous fetch and load, MEM first
        if_req = 1; if_addr = 32'h100;
        mem_req = 1; mem_we = 0; mem_addr = 32'h2000; settle;
        chk("t2_addr_c1", ram_addr, 32'h2000);
        chk("t2_memstall", mem_stall, 1);
        chk("t2_ifstall", if_stall, 1);
        tick; tick; settle;
        chk("t2_memack", mem_ack, 1);
        chk("t2_memrdata", mem_rdata, 32'h1000_2000);
        chk("t2_ifack_c3", if_ack, 0);
        mem_req = 0;
        tick; settle;
        chk("t2_if_grant", ram_en, 1);
        chk("t2_if_addr", ram_addr, 32'h100);
        tick; tick; settle;
        chk("t2_ifack", if_ack, 1);
        chk("t2_ifrdata", if_rdata, 32'h1000_0100);
        if_req = 0;
        tick;

        // 3: store, one-cycle completion
        mem_req = 1; mem_we = 1; mem_addr = 32'h40; mem_wdata = 32'hDEADBEEF; settle;
        chk("t3_en", ram_en, 1);
        chk("t3_we", ram_we, 1);
        chk("t3_addr", ram_addr, 32'h40);
        chk("t3_wdata", ram_wdata, 32'hDEADBEEF);
        tick;
        mem_req = 0; mem_we = 0; if_req = 1; if_addr = 32'h200; settle;
        chk("t3_en_c2", ram_en, 0);
        chk("t3_ack", mem_ack, 1);
        chk("t3_rdata0", mem_rdata, 0);
        tick; settle;
        chk("t3_next_grant", ram_en, 1);
        chk("t3_next_addr", ram_addr, 32'h200);
        tick; tick; settle;
        chk("t3_ifack", if_ack, 1);
        chk("t3_ifrdata", if_rdata, 32'h1000_0200);
        if_req = 0;
        tick;

        // 4: starvation bound: M M M M I M
        mem_req = 1; mem_we = 0; mem_addr = 32'h3000;
        if_req = 1; if_addr = 32'h500;
        for (int g = 0; g < 6; g++) begin
            logic is_if;
            is_if = (g == 4);
            settle;
            chk($sformatf("t4_grant%0d", g), ram_en, 1);
            chk($sformatf("t4_addr%0d", g), ram_addr, is_if ? 32'h500 : 32'h3000);
            tick; tick; settle;
            chk($sformatf("t4_memack%0d", g), mem_ack, !is_if);
            chk($sformatf("t4_ifack%0d", g), if_ack, is_if);
            if (g == 5) begin
                mem_req = 0; if_req = 0;
            end
            tick;
        end

        // 5: killed fetch, then MEM, then a clean fetch
        if_req = 1; if_addr = 32'h600; settle;
        chk("t5_grant", ram_en, 1);
        tick;
        if_kill = 1; settle;
        chk("t5_ack_c2", if_ack, 0);
        tick;
        if_kill = 0; if_req = 0; mem_req = 1; mem_we = 0; mem_addr = 32'h700; settle;
        chk("t5_noack", if_ack, 0);
        chk("t5_rdata0", if_rdata, 0);
        chk("t5_busy_en", ram_en, 0);
        tick; settle;
        chk("t5_mem_grant", ram_en, 1);
        chk("t5_mem_addr", ram_addr, 32'h700);
        tick; tick; settle;
        chk("t5_memack", mem_ack, 1);
        chk("t5_memrdata", mem_rdata, 32'h1000_0700);
        mem_req = 0;
        tick;
        if_req = 1; if_addr = 32'h800; settle;
        chk("t5b_grant", ram_en, 1);
        tick; tick; settle;
        chk("t5b_ifack", if_ack, 1);
        chk("t5b_rdata", if_rdata, 32'h1000_0800);
        if_req = 0;
        tick;

        // 6: reset during a load
        mem_req = 1; mem_we = 0; mem_addr = 32'h900; settle;
        chk("t6_grant", ram_en, 1);
        tick;
        rst = 1; mem_req = 0;
        tick;
        rst = 0; settle;
        chk("t6_memack", mem_ack, 0);
        chk("t6_memrdata", mem_rdata, 0);
        chk("t6_ram_en", ram_en, 0);
        chk("t6_ifack", if_ack, 0);
        chk("t6_stalls", {if_stall, mem_stall}, 0);
        tick;
        if_req = 1; if_addr = 32'hA00; settle;
        chk("t6_idle_grant", ram_en, 1);
        tick; tick; settle;
        chk("t6_ifack", if_ack, 1);
        chk("t6_ifrdata", if_rdata, 32'h1000_0A00);
        if_req = 0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
